// File: rtl/nf_bypass_merge_arb.sv
// Merges the NF (port 0) and bypass (port 1) packet+metadata streams into one egress stream.
// Per-packet arbitration with NF_WEIGHT:1 weighting toward NF, 1-cycle registered output.
module nf_bypass_merge_arb #(
  parameter int unsigned NF_WEIGHT = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned META_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [511:0]      in0_pkt_data,
  input  logic              in0_pkt_valid,
  input  logic              in0_pkt_sop,
  input  logic              in0_pkt_eop,
  input  logic [5:0]        in0_pkt_empty,
  output logic              in0_pkt_ready,
  input  logic              in0_meta_valid,
  input  logic [META_W-1:0] in0_meta_data,
  output logic              in0_meta_ready,
  input  logic [511:0]      in1_pkt_data,
  input  logic              in1_pkt_valid,
  input  logic              in1_pkt_sop,
  input  logic              in1_pkt_eop,
  input  logic [5:0]        in1_pkt_empty,
  output logic              in1_pkt_ready,
  input  logic              in1_meta_valid,
  input  logic [META_W-1:0] in1_meta_data,
  output logic              in1_meta_ready,
  output logic [511:0]      out_pkt_data,
  output logic              out_pkt_sop,
  output logic              out_pkt_eop,
  output logic [5:0]        out_pkt_empty,
  output logic              out_pkt_valid,
  input  logic              out_pkt_almost_full,
  output logic [META_W-1:0] out_meta_data,
  output logic              out_meta_valid,
  input  logic              out_meta_almost_full,
  output logic              out_src,
  output logic [CNT_W-1:0]  stat_pkt0_cnt,
  output logic [CNT_W-1:0]  stat_pkt1_cnt
);

  typedef enum logic {StIdle, StSend} state_t;

  state_t      r_state;
  logic        r_gnt;
  logic [7:0]  r_credit;
  logic        r_pkt_done;
  logic        r_meta_done;

  logic              w_elig0, w_elig1, w_pick, w_send;
  logic              w_pkt_rdy, w_meta_rdy;
  logic              w_pkt_valid, w_pkt_sop, w_pkt_eop, w_meta_valid;
  logic [511:0]      w_pkt_data;
  logic [5:0]        w_pkt_empty;
  logic [META_W-1:0] w_meta_data;
  logic              w_pkt_acc, w_meta_acc, w_pkt_done_d, w_meta_done_d;

  assign w_elig0 = in0_meta_valid & in0_pkt_valid & in0_pkt_sop &
                   ~out_pkt_almost_full & ~out_meta_almost_full;
  assign w_elig1 = in1_meta_valid & in1_pkt_valid & in1_pkt_sop &
                   ~out_pkt_almost_full & ~out_meta_almost_full;

  // Bypass wins a contended grant only once NF has used up its credit.
  assign w_pick = (w_elig0 & w_elig1) ? (32'(r_credit) >= NF_WEIGHT) : w_elig1;

  assign w_send     = (r_state == StSend);
  assign w_pkt_rdy  = w_send & ~r_pkt_done & ~out_pkt_almost_full;
  assign w_meta_rdy = w_send & ~r_meta_done & ~out_meta_almost_full;

  assign in0_pkt_ready  = w_pkt_rdy & ~r_gnt;
  assign in1_pkt_ready  = w_pkt_rdy & r_gnt;
  assign in0_meta_ready = w_meta_rdy & ~r_gnt;
  assign in1_meta_ready = w_meta_rdy & r_gnt;

  assign w_pkt_valid  = r_gnt ? in1_pkt_valid  : in0_pkt_valid;
  assign w_pkt_sop    = r_gnt ? in1_pkt_sop    : in0_pkt_sop;
  assign w_pkt_eop    = r_gnt ? in1_pkt_eop    : in0_pkt_eop;
  assign w_pkt_data   = r_gnt ? in1_pkt_data   : in0_pkt_data;
  assign w_pkt_empty  = r_gnt ? in1_pkt_empty  : in0_pkt_empty;
  assign w_meta_valid = r_gnt ? in1_meta_valid : in0_meta_valid;
  assign w_meta_data  = r_gnt ? in1_meta_data  : in0_meta_data;

  assign w_pkt_acc     = w_pkt_rdy & w_pkt_valid;
  assign w_meta_acc    = w_meta_rdy & w_meta_valid;
  assign w_pkt_done_d  = r_pkt_done | (w_pkt_acc & w_pkt_eop);
  assign w_meta_done_d = r_meta_done | w_meta_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_gnt          <= 1'b0;
      r_credit       <= 8'd0;
      r_pkt_done     <= 1'b0;
      r_meta_done    <= 1'b0;
      out_pkt_valid  <= 1'b0;
      out_meta_valid <= 1'b0;
      out_src        <= 1'b0;
      stat_pkt0_cnt  <= '0;
      stat_pkt1_cnt  <= '0;
    end else begin
      out_pkt_valid  <= w_pkt_acc;
      out_meta_valid <= w_meta_acc;
      if (w_pkt_acc) begin
        out_pkt_data  <= w_pkt_data;
        out_pkt_sop   <= w_pkt_sop;
        out_pkt_eop   <= w_pkt_eop;
        out_pkt_empty <= w_pkt_empty;
      end
      if (w_meta_acc) out_meta_data <= w_meta_data;
      if (w_pkt_acc | w_meta_acc) out_src <= r_gnt;

      unique case (r_state)
        StIdle: begin
          if (w_elig0 | w_elig1) begin
            r_gnt       <= w_pick;
            r_state     <= StSend;
            r_pkt_done  <= 1'b0;
            r_meta_done <= 1'b0;
            if (w_pick)       r_credit <= 8'd0;
            else if (w_elig1) r_credit <= r_credit + 8'd1;
          end
        end
        StSend: begin
          if (w_pkt_done_d & w_meta_done_d) begin
            r_state     <= StIdle;
            r_pkt_done  <= 1'b0;
            r_meta_done <= 1'b0;
            if (r_gnt) stat_pkt1_cnt <= stat_pkt1_cnt + CNT_W'(1);
            else       stat_pkt0_cnt <= stat_pkt0_cnt + CNT_W'(1);
          end else begin
            r_pkt_done  <= w_pkt_done_d;
            r_meta_done <= w_meta_done_d;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nf_bypass_merge_arb.sv
// Bench for nf_bypass_merge_arb: queue-based sources, a packet-level scoreboard checked every
// cycle, and directed scenarios with literal expectations.
module tb_nf_bypass_merge_arb;

  localparam int unsigned NFW = 4;
  localparam int unsigned CW  = 4;
  localparam int unsigned MW  = 64;

  typedef struct {
    logic [511:0] d;
    logic         s;
    logic         e;
    logic [5:0]   m;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [511:0]  pd[2];
  logic          pv[2], ps[2], pe[2], mv[2];
  logic [5:0]    pm[2];
  logic [MW-1:0] md[2];
  logic          pr0, pr1, mr0, mr1;
  logic [511:0]  out_pkt_data;
  logic          out_pkt_sop, out_pkt_eop, out_pkt_valid;
  logic [5:0]    out_pkt_empty;
  logic          out_pkt_almost_full = 1'b0;
  logic [MW-1:0] out_meta_data;
  logic          out_meta_valid;
  logic          out_meta_almost_full = 1'b0;
  logic          out_src;
  logic [CW-1:0] stat_pkt0_cnt, stat_pkt1_cnt;

  nf_bypass_merge_arb #(.NF_WEIGHT(NFW), .CNT_W(CW), .META_W(MW)) dut (
    .clk(clk), .rst(rst),
    .in0_pkt_data(pd[0]), .in0_pkt_valid(pv[0]), .in0_pkt_sop(ps[0]), .in0_pkt_eop(pe[0]),
    .in0_pkt_empty(pm[0]), .in0_pkt_ready(pr0), .in0_meta_valid(mv[0]),
    .in0_meta_data(md[0]), .in0_meta_ready(mr0),
    .in1_pkt_data(pd[1]), .in1_pkt_valid(pv[1]), .in1_pkt_sop(ps[1]), .in1_pkt_eop(pe[1]),
    .in1_pkt_empty(pm[1]), .in1_pkt_ready(pr1), .in1_meta_valid(mv[1]),
    .in1_meta_data(md[1]), .in1_meta_ready(mr1),
    .out_pkt_data(out_pkt_data), .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop),
    .out_pkt_empty(out_pkt_empty), .out_pkt_valid(out_pkt_valid),
    .out_pkt_almost_full(out_pkt_almost_full), .out_meta_data(out_meta_data),
    .out_meta_valid(out_meta_valid), .out_meta_almost_full(out_meta_almost_full),
    .out_src(out_src), .stat_pkt0_cnt(stat_pkt0_cnt), .stat_pkt1_cnt(stat_pkt1_cnt)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Source queues (what the driver presents) and expected-output queues per port.
  beat_t         dq0[$], dq1[$], eq0[$], eq1[$];
  logic [MW-1:0] mq0[$], mq1[$], emq0[$], emq1[$];

  function automatic logic [511:0] mk_data(int p, int id, int b);
    logic [31:0] w;
    w = {8'(p), 8'(id), 16'(b)};
    return {16{w}};
  endfunction

  task automatic push_pkt(input int p, input int id, input int nb);
    beat_t b;
    logic [MW-1:0] m;
    for (int i = 0; i < nb; i++) begin
      b.d = mk_data(p, id, i);
      b.s = (i == 0);
      b.e = (i == nb - 1);
      b.m = (i == nb - 1) ? 6'(id + 1) : 6'd0;
      if (p == 0) begin dq0.push_back(b); eq0.push_back(b); end
      else        begin dq1.push_back(b); eq1.push_back(b); end
    end
    m = {32'hA5A5_0000 | 32'(p), 32'(id)};
    if (p == 0) begin mq0.push_back(m); emq0.push_back(m); end
    else        begin mq1.push_back(m); emq1.push_back(m); end
  endtask

  // Driver: holds each beat/meta until its handshake, sampled mid-cycle.
  initial begin : driver
    bit a0, a1, m0, m1;
    for (int p = 0; p < 2; p++) begin
      pv[p] = 0; ps[p] = 0; pe[p] = 0; pm[p] = 0; pd[p] = '0; mv[p] = 0; md[p] = '0;
    end
    forever begin
      @(negedge clk);
      a0 = pv[0] & pr0 & !rst;
      a1 = pv[1] & pr1 & !rst;
      m0 = mv[0] & mr0 & !rst;
      m1 = mv[1] & mr1 & !rst;
      @(posedge clk);
      #1;
      if (a0 && dq0.size() > 0) dq0.delete(0);
      if (a1 && dq1.size() > 0) dq1.delete(0);
      if (m0 && mq0.size() > 0) mq0.delete(0);
      if (m1 && mq1.size() > 0) mq1.delete(0);
      pv[0] = (dq0.size() != 0);
      pv[1] = (dq1.size() != 0);
      if (pv[0]) begin pd[0] = dq0[0].d; ps[0] = dq0[0].s; pe[0] = dq0[0].e; pm[0] = dq0[0].m; end
      else begin ps[0] = 0; pe[0] = 0; end
      if (pv[1]) begin pd[1] = dq1[0].d; ps[1] = dq1[0].s; pe[1] = dq1[0].e; pm[1] = dq1[0].m; end
      else begin ps[1] = 0; pe[1] = 0; end
      mv[0] = (mq0.size() != 0);
      mv[1] = (mq1.size() != 0);
      if (mv[0]) md[0] = mq0[0];
      if (mv[1]) md[1] = mq1[0];
    end
  end

  // Packet-level model state observed by the compare process.
  int            cyc = 0;
  int            sop_cyc[$], eop_cyc[$], meta_cyc[$], gl[$];
  int            nbeats = 0;
  bit            rst_prev = 1'b1;
  bit            pacc_prev = 0, macc_prev = 0;
  bit            in_pkt = 0, seen_e = 0, seen_m = 0;
  logic          cur_src = 0, last_src = 0;
  logic [CW-1:0] c0 = 0, c1 = 0;

  initial begin : compare
    beat_t b;
    logic [MW-1:0] m;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_prev) begin
        check("rst_pkt_valid", out_pkt_valid, 0);
        check("rst_meta_valid", out_meta_valid, 0);
        check("rst_readies", {pr0, pr1, mr0, mr1}, 0);
        check("rst_stat0", stat_pkt0_cnt, 0);
        check("rst_stat1", stat_pkt1_cnt, 0);
        in_pkt = 0; seen_e = 0; seen_m = 0; c0 = 0; c1 = 0;
      end else begin
        check("pkt_latency", out_pkt_valid, pacc_prev);
        check("meta_latency", out_meta_valid, macc_prev);
        if (out_pkt_valid) begin
          last_src = out_src;
          nbeats++;
          if (in_pkt) check("no_interleave", out_src, cur_src);
          if ((out_src ? eq1.size() : eq0.size()) == 0) begin
            errs++; checks++;
            $display("FAIL unexpected_beat: got src %0d want none", out_src);
          end else begin
            if (out_src) b = eq1.pop_front(); else b = eq0.pop_front();
            check("beat_data", out_pkt_data, b.d);
            check("beat_ctl", {out_pkt_sop, out_pkt_eop, out_pkt_empty}, {b.s, b.e, b.m});
          end
          if (out_pkt_sop) begin
            gl.push_back(int'(out_src)); sop_cyc.push_back(cyc); cur_src = out_src; in_pkt = 1;
          end
          if (out_pkt_eop) begin in_pkt = 0; seen_e = 1; eop_cyc.push_back(cyc); end
        end
        if (out_meta_valid) begin
          last_src = out_src;
          meta_cyc.push_back(cyc);
          if ((out_src ? emq1.size() : emq0.size()) == 0) begin
            errs++; checks++;
            $display("FAIL unexpected_meta: got src %0d want none", out_src);
          end else begin
            if (out_src) m = emq1.pop_front(); else m = emq0.pop_front();
            check("meta_data", out_meta_data, m);
          end
          seen_m = 1;
        end
        if (seen_e && seen_m) begin
          if (last_src) c1++; else c0++;
          seen_e = 0; seen_m = 0;
        end
        check("stat0", stat_pkt0_cnt, c0);
        check("stat1", stat_pkt1_cnt, c1);
      end
      if (out_pkt_almost_full) check("af_pkt_ready", {pr0, pr1}, 0);
      if (out_meta_almost_full) check("af_meta_ready", {mr0, mr1}, 0);
      check("one_port_ready", (pr0 | mr0) & (pr1 | mr1), 0);
      pacc_prev = ((pv[0] & pr0) | (pv[1] & pr1)) & !rst;
      macc_prev = ((mv[0] & mr0) | (mv[1] & mr1)) & !rst;
      rst_prev  = rst;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc_wait(1);
    dq0.delete(); dq1.delete(); mq0.delete(); mq1.delete();
    eq0.delete(); eq1.delete(); emq0.delete(); emq1.delete();
    cyc_wait(1);
    rst = 1'b0;
  endtask

  task automatic drain(input string nm, input int maxc);
    int n = 0;
    while ((dq0.size() + dq1.size() + mq0.size() + mq1.size() + eq0.size() + eq1.size() +
            emq0.size() + emq1.size()) != 0 && n < maxc) begin
      cyc_wait(1);
      n++;
    end
    check(nm, n < maxc, 1);
    cyc_wait(3);
  endtask

  int exp_g[20] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};

  initial begin : stim
    int n;
    cyc_wait(1);
    do_reset();

    // Port 0 only: 4, 1, 2 beat packets back to back.
    sop_cyc.delete(); eop_cyc.delete(); gl.delete();
    push_pkt(0, 1, 4); push_pkt(0, 2, 1); push_pkt(0, 3, 2);
    drain("t1_drain", 200);
    check("t1_stat0", stat_pkt0_cnt, 3);
    check("t1_stat1", stat_pkt1_cnt, 0);
    check("t1_npkts", gl.size(), 3);
    if (sop_cyc.size() == 3 && eop_cyc.size() == 3) begin
      check("t1_len0", eop_cyc[0] - sop_cyc[0], 3);
      check("t1_gap01", sop_cyc[1] - eop_cyc[0], 2);
      check("t1_gap12", sop_cyc[2] - eop_cyc[1], 2);
      check("t1_srcs", {gl[0] != 0, gl[1] != 0, gl[2] != 0}, 0);
    end

    // Both ports contending, 10 two-beat packets each.
    do_reset();
    gl.delete();
    for (int i = 0; i < 10; i++) begin push_pkt(0, 10 + i, 2); push_pkt(1, 30 + i, 2); end
    drain("t2_drain", 1000);
    check("t2_npkts", gl.size(), 20);
    for (int i = 0; i < 20; i++)
      if (i < gl.size()) check($sformatf("t2_grant%0d", i), gl[i], exp_g[i]);
    check("t2_stat0", stat_pkt0_cnt, 10);
    check("t2_stat1", stat_pkt1_cnt, 10);

    // 5-cycle pkt backpressure mid 8-beat packet.
    do_reset();
    nbeats = 0;
    push_pkt(0, 50, 8);
    n = 0;
    while (eq0.size() > 5 && n < 100) begin cyc_wait(1); n++; end
    check("t3_start_timeout", n < 100, 1);
    out_pkt_almost_full = 1'b1;
    cyc_wait(5);
    out_pkt_almost_full = 1'b0;
    drain("t3_drain", 200);
    check("t3_nbeats", nbeats, 8);
    check("t3_stat0", stat_pkt0_cnt, 1);

    // Meta held back by meta backpressure until well after eop.
    do_reset();
    eop_cyc.delete(); meta_cyc.delete();
    push_pkt(0, 60, 3);
    cyc_wait(2);
    out_meta_almost_full = 1'b1;
    n = 0;
    while (eop_cyc.size() == 0 && n < 100) begin cyc_wait(1); n++; end
    check("t4_eop_timeout", n < 100, 1);
    cyc_wait(6);
    check("t4_no_meta_yet", meta_cyc.size(), 0);
    check("t4_stat0_pending", stat_pkt0_cnt, 0);
    out_meta_almost_full = 1'b0;
    drain("t4_drain", 200);
    check("t4_meta_pulses", meta_cyc.size(), 1);
    if (meta_cyc.size() == 1 && eop_cyc.size() == 1)
      check("t4_meta_late", (meta_cyc[0] - eop_cyc[0]) >= 7, 1);
    check("t4_stat0", stat_pkt0_cnt, 1);

    // Reset mid-packet on port 1, then a fresh packet.
    do_reset();
    push_pkt(1, 70, 6);
    n = 0;
    while (eq1.size() > 3 && n < 100) begin cyc_wait(1); n++; end
    check("t5_start_timeout", n < 100, 1);
    do_reset();
    check("t5_stat1_cleared", stat_pkt1_cnt, 0);
    push_pkt(1, 71, 3);
    drain("t5_drain", 200);
    check("t5_stat1", stat_pkt1_cnt, 1);

    // Counter wrap: 17 packets into a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) push_pkt(0, 80 + i, 1);
    drain("t6_drain", 500);
    check("t6_wrap", stat_pkt0_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
